// File: rtl/phy_rx.sv
// phy_rx: two-lane serial receiver; per-lane byte alignment on the 0xBC comma and 8-bit deserialization.
// Optional loss-of-sync detection is compiled in when the macro PHY_RX_LOS_EN is defined.
module phy_rx #(
  parameter int ALIGN_COMS = 4,
  parameter int LOS_BYTES  = 64
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic       rx_in_0,
  input  logic       rx_in_1,
  output logic [7:0] data_out_0,
  output logic       valid_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_1,
  output logic       active_out
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam logic [3:0] COM_LAST = 4'(ALIGN_COMS - 1);

  if ((ALIGN_COMS < 1) || (ALIGN_COMS > 15) || (LOS_BYTES < 1) || (LOS_BYTES > 255)) begin : g_param_check
    $error("phy_rx: ALIGN_COMS must be 1..15 and LOS_BYTES 1..255");
  end

  logic [1:0]      rx_in;
  logic [1:0]      lane_aligned;
  logic [1:0][7:0] lane_data;
  logic [1:0]      lane_valid;
  logic            active_reg;

  assign rx_in = {rx_in_1, rx_in_0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    state_t     state_reg, state_next;
    logic [7:0] sr_reg;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] com_cnt_reg, com_cnt_next;
    logic [7:0] data_reg, data_next;
    logic       valid_reg, valid_next;
    logic       boundary;
    logic       is_comma;
`ifdef PHY_RX_LOS_EN
    localparam logic [7:0] LOS_LAST = 8'(LOS_BYTES - 1);
    logic [7:0] los_cnt_reg, los_cnt_next;
`endif

    // Decisions use the registered shift value, so a byte completed at edge N acts at edge N+1.
    assign boundary = (bit_cnt_reg == 3'd7);
    assign is_comma = (sr_reg == COMMA);

    // The deserializer runs regardless of enable so the lane can relock right away.
    always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
        sr_reg <= '0;
      end else begin
        sr_reg <= {sr_reg[6:0], rx_in[gi]};
      end
    end

    always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      com_cnt_next = com_cnt_reg;
      data_next    = data_reg;
      valid_next   = valid_reg;
`ifdef PHY_RX_LOS_EN
      los_cnt_next = los_cnt_reg;
`endif
      if (!enable) begin
        state_next   = SEARCH;
        bit_cnt_next = '0;
        com_cnt_next = '0;
        data_next    = '0;
        valid_next   = 1'b0;
`ifdef PHY_RX_LOS_EN
        los_cnt_next = '0;
`endif
      end else begin
        case (state_reg)
          SEARCH: begin
            bit_cnt_next = '0;
`ifdef PHY_RX_LOS_EN
            los_cnt_next = '0;
`endif
            if (is_comma) begin
              com_cnt_next = 4'd1;
              state_next   = (ALIGN_COMS == 1) ? ALIGNED : LOCKING;
            end
          end
          LOCKING: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
`ifdef PHY_RX_LOS_EN
            los_cnt_next = '0;
`endif
            if (boundary) begin
              if (is_comma) begin
                com_cnt_next = com_cnt_reg + 4'd1;
                if (com_cnt_reg == COM_LAST) begin
                  state_next = ALIGNED;
                end
              end else begin
                state_next   = SEARCH;
                com_cnt_next = '0;
              end
            end
          end
          ALIGNED: begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (boundary) begin
              // A payload byte equal to the comma is indistinguishable from idle, so it is never valid.
              data_next  = sr_reg;
              valid_next = !is_comma;
`ifdef PHY_RX_LOS_EN
              if (is_comma) begin
                los_cnt_next = '0;
              end else if (los_cnt_reg == LOS_LAST) begin
                state_next   = SEARCH;
                valid_next   = 1'b0;
                los_cnt_next = '0;
                com_cnt_next = '0;
              end else begin
                los_cnt_next = los_cnt_reg + 8'd1;
              end
`endif
            end
          end
          default: begin
            state_next = SEARCH;
          end
        endcase
      end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
        state_reg   <= SEARCH;
        bit_cnt_reg <= '0;
        com_cnt_reg <= '0;
        data_reg    <= '0;
        valid_reg   <= 1'b0;
`ifdef PHY_RX_LOS_EN
        los_cnt_reg <= '0;
`endif
      end else begin
        state_reg   <= state_next;
        bit_cnt_reg <= bit_cnt_next;
        com_cnt_reg <= com_cnt_next;
        data_reg    <= data_next;
        valid_reg   <= valid_next;
`ifdef PHY_RX_LOS_EN
        los_cnt_reg <= los_cnt_next;
`endif
      end
    end

    assign lane_aligned[gi] = (state_reg == ALIGNED);
    assign lane_data[gi]    = data_reg;
    assign lane_valid[gi]   = valid_reg;
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      active_reg <= 1'b0;
    end else if (!enable) begin
      active_reg <= 1'b0;
    end else begin
      active_reg <= &lane_aligned;
    end
  end

  assign data_out_0  = lane_data[0];
  assign valid_out_0 = lane_valid[0];
  assign data_out_1  = lane_data[1];
  assign valid_out_1 = lane_valid[1];
  assign active_out  = active_reg;

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx: self-checking bench for phy_rx; expected outputs are queued with the edge they are due on
// and compared on the following falling clock edge.
module tb_phy_rx;

  logic       clk_8f;
  logic       reset_L;
  logic       enable;
  logic       rx_in_0;
  logic       rx_in_1;
  logic [7:0] data_out_0;
  logic       valid_out_0;
  logic [7:0] data_out_1;
  logic       valid_out_1;
  logic       active_out;

  phy_rx #(
    .ALIGN_COMS(4),
    .LOS_BYTES (64)
  ) dut (
    .clk_8f     (clk_8f),
    .reset_L    (reset_L),
    .enable     (enable),
    .rx_in_0    (rx_in_0),
    .rx_in_1    (rx_in_1),
    .data_out_0 (data_out_0),
    .valid_out_0(valid_out_0),
    .data_out_1 (data_out_1),
    .valid_out_1(valid_out_1),
    .active_out (active_out)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  typedef struct {
    int         at_edge;
    int         sel;
    logic [7:0] exp;
    string      nm;
  } exp_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] d0;
    logic       v0;
    logic [7:0] d1;
    logic       v1;
    logic       act;
  } vec_t;

  exp_t sb[$];
  logic q0[$];
  logic q1[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  localparam int SEL_D0 = 0, SEL_V0 = 1, SEL_D1 = 2, SEL_V1 = 3, SEL_ACT = 4;

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      SEL_D0:  return data_out_0;
      SEL_V0:  return {7'd0, valid_out_0};
      SEL_D1:  return data_out_1;
      SEL_V1:  return {7'd0, valid_out_1};
      default: return {7'd0, active_out};
    endcase
  endfunction

  function automatic void check(input string nm, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", nm, edge_cnt, actual, expected);
    end
  endfunction

  function automatic void expect_at(input int e, input int sel, input logic [7:0] v, input string nm);
    sb.push_back('{e, sel, v, nm});
  endfunction

  function automatic void push_byte(input int lane, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) q0.push_back(b[i]);
      else           q1.push_back(b[i]);
    end
  endfunction

  // Scoreboard: compare every entry due at the edge just passed.
  initial begin
    forever begin
      @(negedge clk_8f);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at_edge == edge_cnt) begin
          check(sb[i].nm, probe(sb[i].sel), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick(input logic b0, input logic b1);
    rx_in_0 = b0;
    rx_in_1 = b1;
    @(posedge clk_8f);
    edge_cnt++;
    #1;
  endtask

  task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) tick(b0[i], b1[i]);
  endtask

  task automatic run(input int n);
    logic b0, b1;
    for (int i = 0; i < n; i++) begin
      b0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
      b1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
      tick(b0, b1);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    enable  = 1'b0;
    q0.delete();
    q1.delete();
    repeat (3) tick(1'b0, 1'b0);
    reset_L = 1'b1;
    enable  = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  initial begin
    int s;
    int n;

    vecs[0] = '{8'hBC, 8'hBC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hBC, 8'hBC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{8'hBC, 8'hBC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hBC, 8'hBC, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hBC, 8'hBC, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1};
    vecs[5] = '{8'h3A, 8'hBC, 8'h3A, 1'b1, 8'hBC, 1'b0, 1'b1};
    vecs[6] = '{8'h55, 8'hBC, 8'h55, 1'b1, 8'hBC, 1'b0, 1'b1};
    vecs[7] = '{8'hBC, 8'hA5, 8'hBC, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[9] = '{8'hBC, 8'hBC, 8'hBC, 1'b0, 8'hBC, 1'b0, 1'b1};

    reset_L = 1'b0;
    enable  = 1'b0;
    rx_in_0 = 1'b0;
    rx_in_1 = 1'b0;

    // Reset state
    repeat (3) tick(1'b1, 1'b1);
    check("rst_d0", data_out_0, 8'h00);
    check("rst_v0", {7'd0, valid_out_0}, 8'h00);
    check("rst_d1", data_out_1, 8'h00);
    check("rst_v1", {7'd0, valid_out_1}, 8'h00);
    check("rst_act", {7'd0, active_out}, 8'h00);

    // Table: both lanes in phase; each byte is checked at N+1 and held through N+8
    do_reset();
    for (int k = 0; k < 10; k++) begin
      send_pair(vecs[k].b0, vecs[k].b1);
      n = edge_cnt;
      $display("vec %0d lane0=%h lane1=%h lsb_edge=%0d", k, vecs[k].b0, vecs[k].b1, n);
      expect_at(n + 1, SEL_D0, vecs[k].d0, "tbl_d0");
      expect_at(n + 1, SEL_V0, {7'd0, vecs[k].v0}, "tbl_v0");
      expect_at(n + 1, SEL_D1, vecs[k].d1, "tbl_d1");
      expect_at(n + 1, SEL_V1, {7'd0, vecs[k].v1}, "tbl_v1");
      expect_at(n + 1, SEL_ACT, {7'd0, vecs[k].act}, "tbl_act");
      expect_at(n + 8, SEL_D0, vecs[k].d0, "tbl_hold_d0");
      expect_at(n + 8, SEL_V0, {7'd0, vecs[k].v0}, "tbl_hold_v0");
      expect_at(n + 8, SEL_D1, vecs[k].d1, "tbl_hold_d1");
    end
    send_pair(8'hBC, 8'hBC);
    repeat (2) tick(1'b0, 1'b0);

    // Lane 1 trails lane 0 by three bits
    do_reset();
    for (int i = 0; i < 3; i++) q1.push_back(1'b0);
    for (int k = 0; k < 5; k++) begin
      push_byte(0, 8'hBC);
      push_byte(1, 8'hBC);
    end
    push_byte(0, 8'h3A);
    push_byte(1, 8'hC3);
    push_byte(0, 8'hBC);
    push_byte(1, 8'hBC);
    s = edge_cnt + 1;
    $display("offset lanes start_edge=%0d", s);
    expect_at(s + 35, SEL_ACT, 8'h00, "off_act_pre");
    expect_at(s + 36, SEL_ACT, 8'h01, "off_act_rise");
    expect_at(s + 47, SEL_D0, 8'hBC, "off_d0_pre");
    expect_at(s + 48, SEL_D0, 8'h3A, "off_d0");
    expect_at(s + 48, SEL_V0, 8'h01, "off_v0");
    expect_at(s + 50, SEL_D1, 8'hBC, "off_d1_pre");
    expect_at(s + 50, SEL_V1, 8'h00, "off_v1_pre");
    expect_at(s + 51, SEL_D1, 8'hC3, "off_d1");
    expect_at(s + 51, SEL_V1, 8'h01, "off_v1");
    run(64);

    // Broken lock sequence on lane 0
    do_reset();
    push_byte(0, 8'hBC);
    push_byte(0, 8'hBC);
    push_byte(0, 8'h12);
    for (int k = 0; k < 5; k++) push_byte(0, 8'hBC);
    for (int k = 0; k < 8; k++) push_byte(1, 8'hBC);
    s = edge_cnt + 1;
    $display("lock abort start_edge=%0d", s);
    expect_at(s + 40, SEL_ACT, 8'h00, "abort_act_mid");
    expect_at(s + 56, SEL_ACT, 8'h00, "abort_act_pre");
    expect_at(s + 57, SEL_ACT, 8'h01, "abort_act_rise");
    expect_at(s + 63, SEL_D0, 8'h00, "abort_d0_pre");
    expect_at(s + 64, SEL_D0, 8'hBC, "abort_d0");
    expect_at(s + 64, SEL_V0, 8'h00, "abort_v0");
    run(68);

    // Asynchronous reset mid-byte while aligned, then relock
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_byte(0, 8'hBC);
      push_byte(1, 8'hBC);
    end
    s = edge_cnt + 1;
    run(44);
    check("mid_act_before", {7'd0, active_out}, 8'h01);
    check("mid_d0_before", data_out_0, 8'hBC);
    #2;
    reset_L = 1'b0;
    #1;
    $display("async reset at edge=%0d", edge_cnt);
    check("arst_d0", data_out_0, 8'h00);
    check("arst_v0", {7'd0, valid_out_0}, 8'h00);
    check("arst_d1", data_out_1, 8'h00);
    check("arst_act", {7'd0, active_out}, 8'h00);
    q0.delete();
    q1.delete();
    repeat (2) tick(1'b0, 1'b0);
    reset_L = 1'b1;
    tick(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      push_byte(0, 8'hBC);
      push_byte(1, 8'hBC);
    end
    s = edge_cnt + 1;
    expect_at(s + 32, SEL_ACT, 8'h00, "relock_act_pre");
    expect_at(s + 33, SEL_ACT, 8'h01, "relock_act_rise");
    expect_at(s + 39, SEL_D0, 8'h00, "relock_d0_pre");
    expect_at(s + 40, SEL_D0, 8'hBC, "relock_d0");
    run(50);

    // Enable low clears outputs and drops lock
    enable = 1'b0;
    tick(1'b0, 1'b0);
    $display("enable low at edge=%0d", edge_cnt);
    check("en_act", {7'd0, active_out}, 8'h00);
    check("en_d0", data_out_0, 8'h00);
    check("en_d1", data_out_1, 8'h00);
    enable = 1'b1;
    repeat (16) tick(1'b0, 1'b0);
    check("en_act_after", {7'd0, active_out}, 8'h00);

    // Long run of payload after lock
    do_reset();
    for (int k = 0; k < 4; k++) push_byte(0, 8'hBC);
    for (int k = 0; k < 66; k++) push_byte(0, 8'h5A);
    for (int k = 0; k < 70; k++) push_byte(1, 8'hBC);
    s = edge_cnt + 1;
    $display("payload run start_edge=%0d", s);
    expect_at(s + 536, SEL_V0, 8'h01, "los_v0_63");
    expect_at(s + 544, SEL_D0, 8'h5A, "los_d0_64");
    expect_at(s + 544, SEL_ACT, 8'h01, "los_act_64");
`ifdef PHY_RX_LOS_EN
    expect_at(s + 544, SEL_V0, 8'h00, "los_v0_drop");
    expect_at(s + 545, SEL_ACT, 8'h00, "los_act_fall");
`else
    expect_at(s + 544, SEL_V0, 8'h01, "los_v0_kept");
    expect_at(s + 552, SEL_V0, 8'h01, "los_v0_kept2");
    expect_at(s + 545, SEL_ACT, 8'h01, "los_act_kept");
`endif
    run(8 * 70 + 4);
    repeat (2) tick(1'b0, 1'b0);

    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL %s never_reached due_edge=%0d", sb[i].nm, sb[i].at_edge);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
